// File: rtl/adc_pkg.sv
// Shared types and constants for the soft SAR ADC controller and the battery-level logic
// that consumes its results.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    DECIDE,
    DONE
  } adc_state_e;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 3;

  // Battery-level thresholds, kept here so the reader and the converter agree on the scale.
  localparam int BATT_LVL_HI  = 2699;
  localparam int BATT_LVL_MID = 2389;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Request/result side of the converter: start, channel, power-down in; eoc, dout, busy out.
interface sar_adc_ctrl_if #(
  parameter int DATA_W = adc_pkg::ADC_DATA_W,
  parameter int CH_W   = adc_pkg::ADC_CH_W
) ();
  logic              soc;
  logic [CH_W-1:0]   s;
  logic [2:0]        pd;
  logic              eoc;
  logic [DATA_W-1:0] dout;
  logic              busy;

  modport master (output soc, s, pd, input eoc, dout, busy);
  modport slave  (input soc, s, pd, output eoc, dout, busy);
endinterface

// File: rtl/adc_wait_cnt.sv
// Loadable down-counter; done is high during the last cycle of a loaded wait,
// so a load of N keeps the caller in its state for exactly N cycles.
module adc_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign done = (cnt <= W'(1));
endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples the selected channel, then resolves
// DATA_W bits MSB-first from the comparator, reporting the code with a one-cycle eoc.
module sar_adc_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int CH_W       = ADC_CH_W,
  parameter int SAMPLE_CYC = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sar_adc_ctrl_if.slave     bus,
  input  logic              cmp_in,
  output logic [CH_W-1:0]   mux_sel,
  output logic              sh_hold,
  output logic [DATA_W-1:0] dac_code
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(max_int(SAMPLE_CYC, SETTLE_CYC) + 1);
  localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};

  adc_state_e        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] code_nxt, dout_nxt, trial;
  logic [CH_W-1:0]   mux_nxt;
  logic              busy_nxt, hold_nxt, eoc_nxt;
  logic              cnt_load, cnt_done;
  logic [CNT_W-1:0]  cnt_val;
  logic              pd_on;

  assign pd_on = |bus.pd;

  adc_wait_cnt #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      dac_code <= '0;
      mux_sel  <= '0;
      sh_hold  <= 1'b0;
      bus.dout <= '0;
      bus.busy <= 1'b0;
      bus.eoc  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      dac_code <= code_nxt;
      mux_sel  <= mux_nxt;
      sh_hold  <= hold_nxt;
      bus.dout <= dout_nxt;
      bus.busy <= busy_nxt;
      bus.eoc  <= eoc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    code_nxt  = dac_code;
    dout_nxt  = bus.dout;
    mux_nxt   = mux_sel;
    busy_nxt  = bus.busy;
    hold_nxt  = sh_hold;
    eoc_nxt   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = CNT_W'(SETTLE_CYC);
    // Current trial code with the bit under test resolved by the comparator.
    trial     = dac_code;
    if (!cmp_in) trial[idx] = 1'b0;

    if (state != IDLE && pd_on) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      hold_nxt  = 1'b0;
      code_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.soc && !pd_on) begin
            mux_nxt   = bus.s;
            busy_nxt  = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(SAMPLE_CYC);
            state_nxt = SAMPLE;
          end
        end
        SAMPLE: begin
          if (cnt_done) begin
            hold_nxt  = 1'b1;
            idx_nxt   = IDX_W'(DATA_W-1);
            code_nxt  = MSB;
            cnt_load  = 1'b1;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_done) state_nxt = DECIDE;
        end
        DECIDE: begin
          code_nxt = trial;
          if (idx != '0) begin
            code_nxt[idx - IDX_W'(1)] = 1'b1;
            idx_nxt   = idx - IDX_W'(1);
            cnt_load  = 1'b1;
            state_nxt = SETTLE;
          end else begin
            dout_nxt  = trial;
            state_nxt = DONE;
          end
        end
        DONE: begin
          eoc_nxt   = 1'b1;
          hold_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          code_nxt  = '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench: comparator model drives cmp_in from a test voltage code; expected
// results are queued at conversion start and checked by an eoc monitor.
module tb_sar_adc_ctrl;
  import adc_pkg::*;

  localparam int DW = 12;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmp_in;
  logic [CW-1:0] mux_sel;
  logic          sh_hold;
  logic [DW-1:0] dac_code;

  int vin = 1000;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int    dout;
    int    at;
    string name;
  } exp_t;

  exp_t sb[$];

  sar_adc_ctrl_if #(.DATA_W(DW), .CH_W(CW)) bus ();

  sar_adc_ctrl #(.DATA_W(DW), .CH_W(CW), .SAMPLE_CYC(8), .SETTLE_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cmp_in   (cmp_in),
    .mux_sel  (mux_sel),
    .sh_hold  (sh_hold),
    .dac_code (dac_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cmp_in = (vin >= int'(dac_code));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: eoc seen, none expected (cycle %0d)", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string name, input int d, input int at);
    exp_t e;
    e.name = name;
    e.dout = d;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Monitor: every eoc must match the head of the scoreboard in value and cycle.
  logic          prev_eoc = 1'b0;
  logic [DW-1:0] prev_dout = '0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.eoc === 1'b1) begin
      if (prev_eoc) fail_evt("eoc_width");
      if (sb.size() == 0) fail_evt("unexpected_eoc");
      else begin
        e = sb.pop_front();
        check({e.name, "_dout"}, int'(bus.dout), e.dout);
        check({e.name, "_cycle"}, cyc, e.at);
        check({e.name, "_dout_pre_eoc"}, int'(prev_dout), e.dout);
      end
    end
    prev_eoc  <= bus.eoc;
    prev_dout <= bus.dout;
  end

  task automatic run_conv(input string name, input logic [CW-1:0] ch, input int v, input int exp);
    bus.s   = ch;
    vin     = v;
    bus.soc = 1'b1;
    push(name, exp, cyc + 70);
    tick(1);
    bus.soc = 1'b0;
    tick(75);
  endtask

  initial begin
    int t0;
    bus.soc = 1'b1;
    bus.pd  = 3'b000;
    bus.s   = 3'b101;

    // Reset held with soc high: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_outputs", int'({bus.eoc, bus.busy, sh_hold, mux_sel, dac_code, bus.dout}), 0);
    end
    rst_n = 1'b1;
    push("post_reset", 1000, cyc + 70);
    tick(1);
    check("post_reset_busy", int'(bus.busy), 1);
    check("post_reset_mux", int'(mux_sel), 5);
    bus.soc = 1'b0;
    tick(75);

    // Nominal conversion on channel 1.
    t0 = cyc;
    bus.s = 3'b001;
    vin = 2700;
    bus.soc = 1'b1;
    push("nominal", 2700, t0 + 70);
    tick(1);
    bus.soc = 1'b0;
    check("nom_mux", int'(mux_sel), 1);
    tick(3);
    check("nom_track", int'(sh_hold), 0);
    check("nom_busy", int'(bus.busy), 1);
    tick(5);
    check("nom_first_dac", int'(dac_code), 12'h800);
    check("nom_hold", int'(sh_hold), 1);
    tick(59);
    check("nom_dout_old", int'(bus.dout), 1000);
    tick(1);
    check("nom_dout_new", int'(bus.dout), 2700);
    check("nom_eoc_not_yet", int'(bus.eoc), 0);
    tick(6);
    check("nom_idle_busy", int'(bus.busy), 0);

    run_conv("zero", 3'b010, 0, 12'h000);
    run_conv("full", 3'b010, 4095, 12'hFFF);

    // Continuous mode with a channel change mid-conversion.
    t0 = cyc;
    bus.s = 3'b010;
    vin = BATT_LVL_MID;
    bus.soc = 1'b1;
    push("cont0", 2389, t0 + 70);
    push("cont1", 2390, t0 + 140);
    tick(1);
    check("cont_mux0", int'(mux_sel), 2);
    tick(29);
    bus.s = 3'b110;
    tick(10);
    check("cont_mux_hold", int'(mux_sel), 2);
    tick(29);
    vin = 2390;
    tick(2);
    check("cont_mux1", int'(mux_sel), 6);
    check("cont_busy1", int'(bus.busy), 1);
    tick(29);
    bus.soc = 1'b0;
    tick(45);
    check("cont_stop_busy", int'(bus.busy), 0);

    // Power-down abort at cycle 30, then soc ignored while pd is set.
    t0 = cyc;
    bus.s = 3'b100;
    vin = 1234;
    bus.soc = 1'b1;
    tick(1);
    bus.soc = 1'b0;
    tick(29);
    bus.pd = 3'b010;
    tick(1);
    check("pd_busy", int'(bus.busy), 0);
    check("pd_hold", int'(sh_hold), 0);
    check("pd_dac", int'(dac_code), 0);
    check("pd_dout_kept", int'(bus.dout), 2390);
    bus.soc = 1'b1;
    tick(10);
    check("pd_no_start", int'(bus.busy), 0);
    bus.pd = 3'b000;
    bus.soc = 1'b0;
    tick(2);

    // Reset in the middle of a conversion.
    bus.s = 3'b011;
    vin = 500;
    bus.soc = 1'b1;
    tick(1);
    bus.soc = 1'b0;
    tick(39);
    rst_n = 1'b0;
    tick(1);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_hold", int'(sh_hold), 0);
    check("midrst_dac", int'(dac_code), 0);
    check("midrst_mux", int'(mux_sel), 0);
    check("midrst_dout", int'(bus.dout), 0);
    rst_n = 1'b1;
    tick(1);
    run_conv("after_rst", 3'b111, 3000, 3000);

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
